data_mem_ctrl: RTL and testbench

//  Data-memory controller fed by the core's MEM stage, returning load data and ready to it.

---
 rtl/data_mem_ctrl_pkg.sv | 37 +++
 rtl/data_mem_ctrl_mem_lane_align.sv | 48 ++++
 rtl/data_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : data_mem_ctrl_pkg
// Brief  : Shared size codes, FSM states and func3 normalisation for data_mem_ctrl.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package data_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_DONE = 2'd2
    } dmem_state_t;

    // Undefined size codes behave as full-word accesses.
    function automatic mem_size_t norm_size(input logic [2:0] f3);
        case (f3)
            3'b000:  return MEM_B;
            3'b001:  return MEM_H;
            3'b100:  return MEM_BU;
            3'b101:  return MEM_HU;
            default: return MEM_W;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_ctrl_mem_lane_align.sv
//------------------------------------------------------------------------------
// Module : mem_lane_align
// Brief  : Byte-lane steering for stores and lane extraction/extension for loads.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    mem_size_t   w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_size  = norm_size(func3_i);
        w_byte  = rword_i[{addr_lo_i, 3'b000} +: 8];
        w_half  = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        be_o    = 4'b1111;
        wword_o = wdata_i;
        rdata_o = rword_i;
        case (w_size)
            MEM_B, MEM_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = (w_size == MEM_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            end
            MEM_H, MEM_HU: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                rdata_o = (w_size == MEM_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
//------------------------------------------------------------------------------
// Module : data_mem_ctrl
// Brief  : Wait-stated byte/half/word data memory for the MEM stage.
//          Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DM_MEM_DEPTH = 4096,
    parameter int DATA_WIDTH   = 32,
    parameter int FUNC3_WIDTH  = 3,
    parameter int WAIT_STATES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   memRead,
    input  logic                   memWrite,
    input  logic [FUNC3_WIDTH-1:0] func3,
    input  logic [DATA_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  wData,
    output logic [DATA_WIDTH-1:0]  rData,
    output logic                   ready
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic                   misalignErr
`endif
);

    localparam int         IDX_W    = $clog2(DM_MEM_DEPTH);
    localparam logic [3:0] WS       = 4'(WAIT_STATES);
    localparam logic [3:0] WS_M1    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0] ST_IDLE  = DM_IDLE;
    localparam logic [1:0] ST_WAIT  = DM_WAIT;
    localparam logic [1:0] ST_DONE  = DM_DONE;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             w_req, w_done, w_ready, w_mis, w_we;
    mem_size_t        w_size;
    logic [1:0]       w_addr_lo;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rword, w_wword, w_ld;
    logic [3:0]       w_be;
    logic [31:0]      mem_q [DM_MEM_DEPTH];
    logic             unused_addr_hi;

    assign w_req          = memRead | memWrite;
    assign w_size         = norm_size(func3[2:0]);
    assign w_idx          = addr[IDX_W+1:2];
    assign unused_addr_hi = ^addr[DATA_WIDTH-1:IDX_W+2];

    // The request cycle in IDLE counts as the first stall cycle, so an access spans WAIT_STATES+1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_done  = 1'b0;
        w_ready = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    if (WS == 4'd0) begin
                        w_done = 1'b1;
                    end else begin
                        w_ready = 1'b0;
                        cnt_d   = WS_M1;
                        state_d = (WS == 4'd1) ? ST_DONE : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_ready = 1'b0;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_DONE;
            end
            ST_DONE: begin
                w_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign_q;

    assign w_addr_lo   = addr[1:0];
    assign w_mis       = (((w_size == MEM_H) || (w_size == MEM_HU)) && addr[0])
                       || ((w_size == MEM_W) && (addr[1:0] != 2'b00));
    assign misalignErr = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (w_done && w_mis) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign w_mis = 1'b0;

    always_comb begin
        case (w_size)
            MEM_H, MEM_HU: w_addr_lo = {addr[1], 1'b0};
            MEM_W:         w_addr_lo = 2'b00;
            default:       w_addr_lo = addr[1:0];
        endcase
    end
`endif

    assign w_rword = mem_q[w_idx];

    mem_lane_align u_align (
        .func3_i   (func3[2:0]),
        .addr_lo_i (w_addr_lo),
        .wdata_i   (wData[31:0]),
        .rword_i   (w_rword),
        .be_o      (w_be),
        .wword_o   (w_wword),
        .rdata_o   (w_ld)
    );

    // A reset landing on the completion edge must not commit the store.
    assign w_we = w_done && memWrite && !w_mis && !rst;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) mem_q[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    assign ready = w_ready;
    assign rData = (w_done && memRead && !memWrite && !w_mis) ? DATA_WIDTH'(w_ld) : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_data_mem_ctrl
// Brief  : Self-checking bench for data_mem_ctrl against a byte-addressed memory model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_data_mem_ctrl;

    localparam int DEPTH = 4096;
    localparam int WS    = 2;
    localparam int NBYTE = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [2:0]  func3 = 3'b010;
    logic [31:0] addr = '0, wData = '0;
    logic [31:0] rData;
    logic        ready;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misalignErr;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mb [NBYTE];
    logic        model_err = 1'b0;
    logic [7:0]  exp_trace;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DM_MEM_DEPTH (DEPTH),
        .DATA_WIDTH   (32),
        .FUNC3_WIDTH  (3),
        .WAIT_STATES  (WS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .func3       (func3),
        .addr        (addr),
        .wData       (wData),
        .rData       (rData),
        .ready       (ready)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .misalignErr (misalignErr)
`endif
    );

    // Access size in bytes from the size code; unknown codes are words.
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (a % nbytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_eff(input logic [2:0] f3, input logic [31:0] a);
        return a - (a % nbytes(f3));
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] e;
        if (model_mis(f3, a)) return;
        e = model_eff(f3, a);
        for (int k = 0; k < nbytes(f3); k++) mb[(e + k) % NBYTE] = d[8*k +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] e, v;
        int n;
        if (model_mis(f3, a)) return 32'h0;
        e = model_eff(f3, a);
        n = nbytes(f3);
        v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(mb[(e + k) % NBYTE]) << (8 * k));
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Starts at posedge+1; returns ready trace (bit per cycle) and rData in the ready cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rv, output logic [7:0] trace);
        int cyc;
        memRead = rd; memWrite = wr; func3 = f3; addr = a; wData = d;
        trace = '0; rv = '0; cyc = 0;
        forever begin
            @(negedge clk);
            trace[cyc] = ready;
            cyc++;
            if (ready) begin
                rv = rData;
                break;
            end
            if (cyc >= 8) break;
        end
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rv;
        logic [7:0]  tr;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_err = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready); end
        checks++;
        if (rData !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", rData); end
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++;
        if (misalignErr !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b want=0", misalignErr); end
`endif
        @(posedge clk); #1;
        for (int w = 0; w < 64; w++) begin
            access(1'b0, 1'b1, 3'b010, 32'(w * 4), 32'h0, rv, tr);
            model_store(3'b010, 32'(w * 4), 32'h0);
        end
    endtask

    task automatic test_word();
        logic [31:0] rv;
        logic [7:0]  tr;
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rv, tr);
        model_store(3'b010, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (tr !== exp_trace) begin errors++; $display("FAIL sw_ready_trace got=%b want=%b", tr, exp_trace); end
        checks++;
        if (rv !== 32'h0) begin errors++; $display("FAIL sw_rdata got=%h want=0", rv); end
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rv, tr);
        checks++;
        if (tr !== exp_trace) begin errors++; $display("FAIL lw_ready_trace got=%b want=%b", tr, exp_trace); end
        checks++;
        if (rv !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_0x10 got=%h want=deadbeef", rv); end
    endtask

    task automatic test_subword();
        logic [31:0] rv;
        logic [7:0]  tr;
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b010, 3'b001};
        logic [31:0] as  [4] = '{32'h21, 32'h21, 32'h20, 32'h22};
        access(1'b0, 1'b1, 3'b000, 32'h21, 32'h0000_0080, rv, tr);
        model_store(3'b000, 32'h21, 32'h0000_0080);
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 1'b0, f3s[i], as[i], 32'h0, rv, tr);
            checks++;
            if (rv !== model_load(f3s[i], as[i]))
                begin errors++; $display("FAIL sb_load f3=%b a=%h got=%h want=%h", f3s[i], as[i], rv, model_load(f3s[i], as[i])); end
        end
        access(1'b0, 1'b1, 3'b001, 32'h32, 32'h1234_ABCD, rv, tr);
        model_store(3'b001, 32'h32, 32'h1234_ABCD);
        access(1'b1, 1'b0, 3'b001, 32'h32, 32'h0, rv, tr);
        checks++;
        if (rv !== 32'hFFFF_ABCD) begin errors++; $display("FAIL lh_0x32 got=%h want=ffffabcd", rv); end
        access(1'b1, 1'b0, 3'b101, 32'h30, 32'h0, rv, tr);
        checks++;
        if (rv !== 32'h0) begin errors++; $display("FAIL lhu_0x30 got=%h want=0", rv); end
        access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, rv, tr);
        checks++;
        if (rv !== 32'hABCD_0000) begin errors++; $display("FAIL lw_0x30 got=%h want=abcd0000", rv); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rv, d0;
        logic [7:0]  tr;
        d0 = $urandom | 32'h1;
        access(1'b0, 1'b1, 3'b010, 32'h40, d0, rv, tr);
        model_store(3'b010, 32'h40, d0);
        memWrite = 1'b1; func3 = 3'b010; addr = 32'h40; wData = 32'h55;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; memWrite = 1'b0;
        model_err = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want=1", ready); end
        @(posedge clk); #1;
        access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, rv, tr);
        checks++;
        if (rv !== d0) begin errors++; $display("FAIL abort_contents got=%h want=%h", rv, d0); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  tr;
        logic [31:0] got [2];
        int n = 0;
        got[0] = '0; got[1] = '0;
        memRead = 1'b1; memWrite = 1'b0; func3 = 3'b010; addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tr[c] = ready;
            if (ready && n < 2) begin got[n] = rData; n++; end
            @(posedge clk); #1;
            if (c == 2) addr = 32'h14;
        end
        memRead = 1'b0;
        checks++;
        if (tr !== 6'b100100) begin errors++; $display("FAIL b2b_ready_trace got=%b want=100100", tr); end
        checks++;
        if (got[0] !== model_load(3'b010, 32'h10)) begin errors++; $display("FAIL b2b_first got=%h want=%h", got[0], model_load(3'b010, 32'h10)); end
        checks++;
        if (got[1] !== model_load(3'b010, 32'h14)) begin errors++; $display("FAIL b2b_second got=%h want=%h", got[1], model_load(3'b010, 32'h14)); end
    endtask

    task automatic test_misalign();
        logic [31:0] rv;
        logic [7:0]  tr;
        access(1'b1, 1'b0, 3'b010, 32'h11, 32'h0, rv, tr);
        if (model_mis(3'b010, 32'h11)) model_err = 1'b1;
        checks++;
        if (rv !== model_load(3'b010, 32'h11)) begin errors++; $display("FAIL lw_0x11 got=%h want=%h", rv, model_load(3'b010, 32'h11)); end
        checks++;
        if (tr !== exp_trace) begin errors++; $display("FAIL mis_ready_trace got=%b want=%b", tr, exp_trace); end
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rv, tr);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++;
        if (misalignErr !== 1'b1) begin errors++; $display("FAIL misalign_sticky got=%b want=1", misalignErr); end
`endif
        checks++;
        if (rv !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_after_mis got=%h want=deadbeef", rv); end
    endtask

    task automatic test_both_and_wrap();
        logic [31:0] rv, d0;
        logic [7:0]  tr;
        d0 = $urandom;
        access(1'b1, 1'b1, 3'b010, 32'h48, d0, rv, tr);
        model_store(3'b010, 32'h48, d0);
        checks++;
        if (rv !== 32'h0) begin errors++; $display("FAIL rw_both_rdata got=%h want=0", rv); end
        access(1'b0, 1'b1, 3'b010, 32'h0005_004C, 32'hCAFE_F00D, rv, tr);
        model_store(3'b010, 32'h0005_004C, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 3'b010, 32'h4C, 32'h0, rv, tr);
        checks++;
        if (rv !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_load got=%h want=cafef00d", rv); end
        access(1'b1, 1'b0, 3'b010, 32'h48, 32'h0, rv, tr);
        checks++;
        if (rv !== d0) begin errors++; $display("FAIL rw_both_stored got=%h want=%h", rv, d0); end
    endtask

    task automatic test_random();
        logic [31:0] rv, a, d, expv;
        logic [7:0]  tr;
        logic [2:0]  f3;
        logic        rd, wr;
        for (int it = 0; it < 80; it++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255)) | (32'($urandom_range(0, 3)) << 24);
            d  = $urandom;
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            expv = (rd && !wr) ? model_load(f3, a) : 32'h0;
            access(rd, wr, f3, a, d, rv, tr);
            if (wr) model_store(f3, a, d);
            if (model_mis(f3, a)) model_err = 1'b1;
            checks++;
            if (rv !== expv || tr !== exp_trace)
                begin errors++; $display("FAIL rand it=%0d rd=%b wr=%b f3=%b a=%h got=%h/%b want=%h/%b", it, rd, wr, f3, a, rv, tr, expv, exp_trace); end
`ifdef DMEM_MISALIGN_TRAP_EN
            checks++;
            if (misalignErr !== model_err) begin errors++; $display("FAIL rand_misalign it=%0d got=%b want=%b", it, misalignErr, model_err); end
`endif
        end
    endtask

    initial begin
        exp_trace = 8'(1 << WS);
        test_reset();
        test_word();
        test_subword();
        test_reset_abort();
        test_word();
        test_back_to_back();
        test_misalign();
        test_both_and_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
